// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, shared ALU used as the PC incrementer,
// next-PC select and the fetch/decode pipeline register.

module pc_register #(
    parameter int                 WIDTH    = 16,
    parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [WIDTH-1:0] address_in,
    output logic [WIDTH-1:0] address_out
);

    logic [WIDTH-1:0] address_d;
    logic [WIDTH-1:0] address_q;

    always_comb begin
        address_d = address_q;
        if (!stall) begin
            address_d = address_in;
        end
    end

    // NOTE: state registers use non-blocking (<=) so every flop samples its
    // inputs as they were just before the edge, independent of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            address_q <= RESET_PC;
        end else begin
            address_q <= address_d;
        end
    end

    assign address_out = address_q;

endmodule


module alu #(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] alu_result,
    output logic             flag_n,
    output logic             flag_z
);

    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_ADD  = 3'b001,
        ALU_SUB  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_SHL  = 3'b101,
        ALU_SHR  = 3'b110,
        ALU_PASS = 3'b111
    } alu_op_e;

    // NOTE: the result gets a default before the case so no path through the
    // block leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        alu_result = '0;
        case (alu_op_e'(alu_op))
            ALU_AND:  alu_result = src_a & src_b;
            ALU_ADD:  alu_result = src_a + src_b;
            ALU_SUB:  alu_result = src_a - src_b;
            ALU_OR:   alu_result = src_a | src_b;
            ALU_XOR:  alu_result = src_a ^ src_b;
            ALU_SHL:  alu_result = src_a << src_b[3:0];
            ALU_SHR:  alu_result = src_a >> src_b[3:0];
            ALU_PASS: alu_result = src_b;
            default:  alu_result = '0;
        endcase
    end

    assign flag_n = alu_result[WIDTH-1];
    assign flag_z = (alu_result == '0);

endmodule


module pc_mux #(
    parameter int WIDTH = 16
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] in_seq,
    input  logic [WIDTH-1:0] in_redirect,
    output logic [WIDTH-1:0] pc_next
);

    assign pc_next = sel ? in_redirect : in_seq;

endmodule


module fetch_decode_register #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic [WIDTH-1:0] instruction_in,
    output logic [WIDTH-1:0] instruction_out
);

    logic [WIDTH-1:0] instruction_d;
    logic [WIDTH-1:0] instruction_q;

    // Flush beats stall so a squashed slot becomes a NOP even while held.
    always_comb begin
        instruction_d = instruction_q;
        if (flush) begin
            instruction_d = '0;
        end else if (!stall) begin
            instruction_d = instruction_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instruction_q <= '0;
        end else begin
            instruction_q <= instruction_d;
        end
    end

    assign instruction_out = instruction_q;

endmodule


module fetch_stage #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = 16'h0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             NI,
    input  logic [WIDTH-1:0] srcB,
    input  logic             stall,
    input  logic             flush,
    input  logic [WIDTH-1:0] instruction_fetch,
    output logic [WIDTH-1:0] address_pc,
    output logic [WIDTH-1:0] pc_plus_one,
    output logic [WIDTH-1:0] instruction_decode
);

    logic [WIDTH-1:0] pc_next;
    logic             pc_flag_n_unused;
    logic             pc_flag_z_unused;

    pc_register #(
        .WIDTH    (WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .address_in  (pc_next),
        .address_out (address_pc)
    );

    // Incrementer is the shared ALU hard-wired to ADD; its flags are not used
    // on the fetch path, so a PC wrap has no side effect.
    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .alu_op     (3'b001),
        .src_a      (WIDTH'(1)),
        .src_b      (address_pc),
        .alu_result (pc_plus_one),
        .flag_n     (pc_flag_n_unused),
        .flag_z     (pc_flag_z_unused)
    );

    pc_mux #(
        .WIDTH (WIDTH)
    ) u_pc_mux (
        .sel         (NI),
        .in_seq      (pc_plus_one),
        .in_redirect (srcB),
        .pc_next     (pc_next)
    );

    fetch_decode_register #(
        .WIDTH (WIDTH)
    ) u_fetch_decode_register (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .flush           (flush),
        .instruction_in  (instruction_fetch),
        .instruction_out (instruction_decode)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage plus a standalone ALU instance.

module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        NI;
    logic [15:0] srcB;
    logic        stall;
    logic        flush;
    logic [15:0] instruction_fetch;
    logic [15:0] address_pc;
    logic [15:0] pc_plus_one;
    logic [15:0] instruction_decode;

    logic [15:0] mem_key;

    logic [2:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_result;
    logic        alu_n;
    logic        alu_z;

    int tests_run;
    int tests_failed;

    fetch_stage #(
        .WIDTH    (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .NI                 (NI),
        .srcB               (srcB),
        .stall              (stall),
        .flush              (flush),
        .instruction_fetch  (instruction_fetch),
        .address_pc         (address_pc),
        .pc_plus_one        (pc_plus_one),
        .instruction_decode (instruction_decode)
    );

    alu #(
        .WIDTH (16)
    ) u_alu_standalone (
        .alu_op     (alu_op),
        .src_a      (alu_a),
        .src_b      (alu_b),
        .alu_result (alu_result),
        .flag_n     (alu_n),
        .flag_z     (alu_z)
    );

    // Combinational instruction memory: word at address A is A ^ mem_key.
    assign instruction_fetch = address_pc ^ mem_key;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] observed,
                         input logic [15:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_case(input string tag, input logic [2:0] op,
                            input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] exp_r, input logic exp_n,
                            input logic exp_z);
        alu_op = op;
        alu_a  = a;
        alu_b  = b;
        #1;
        check({tag, "_result"}, alu_result, exp_r);
        check({tag, "_n"}, {15'd0, alu_n}, {15'd0, exp_n});
        check({tag, "_z"}, {15'd0, alu_z}, {15'd0, exp_z});
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset   = 1'b0;
        NI      = 1'b0;
        srcB    = 16'h0000;
        stall   = 1'b0;
        flush   = 1'b0;
        mem_key = 16'h0000;
        alu_op  = 3'b000;
        alu_a   = 16'h0000;
        alu_b   = 16'h0000;

        // Reset state
        edge_step();
        edge_step();
        check("reset_pc", address_pc, 16'h0000);
        check("reset_pc1", pc_plus_one, 16'h0001);
        check("reset_id", instruction_decode, 16'h0000);
        reset = 1'b1;

        // Sequential fetch after release
        edge_step();
        edge_step();
        edge_step();
        check("seq_pc3", address_pc, 16'h0003);
        check("seq_id2", instruction_decode, 16'h0002);
        edge_step();
        edge_step();
        check("seq_pc5", address_pc, 16'h0005);

        // Redirect at PC=5
        NI   = 1'b1;
        srcB = 16'h0040;
        edge_step();
        NI   = 1'b0;
        srcB = 16'h0000;
        check("redir_pc", address_pc, 16'h0040);
        check("redir_id_old", instruction_decode, 16'h0005);
        edge_step();
        check("redir_pc_next", address_pc, 16'h0041);
        check("redir_id_target", instruction_decode, 16'h0040);

        // Wrap through FFFF, with non-trivial memory contents
        mem_key = 16'h5A00;
        NI   = 1'b1;
        srcB = 16'hFFFF;
        edge_step();
        NI   = 1'b0;
        check("wrap_pc_ffff", address_pc, 16'hFFFF);
        check("wrap_pc1_ffff", pc_plus_one, 16'h0000);
        check("wrap_id", instruction_decode, 16'h5A41);
        edge_step();
        check("wrap_pc0", address_pc, 16'h0000);
        check("wrap_pc1", pc_plus_one, 16'h0001);
        check("wrap_id_ffff", instruction_decode, 16'hA5FF);

        // Stall two edges; a concurrent redirect is lost
        stall = 1'b1;
        NI    = 1'b1;
        srcB  = 16'h0200;
        edge_step();
        check("stall1_pc", address_pc, 16'h0000);
        check("stall1_id", instruction_decode, 16'hA5FF);
        edge_step();
        check("stall2_pc", address_pc, 16'h0000);
        check("stall2_id", instruction_decode, 16'hA5FF);
        stall = 1'b0;
        NI    = 1'b0;
        srcB  = 16'h0000;
        edge_step();
        check("unstall_pc", address_pc, 16'h0001);
        check("unstall_id", instruction_decode, 16'h5A00);

        // Flush alone: NOP loaded while PC advances
        flush = 1'b1;
        edge_step();
        flush = 1'b0;
        check("flush_pc", address_pc, 16'h0002);
        check("flush_id", instruction_decode, 16'h0000);
        edge_step();
        check("post_flush_id", instruction_decode, 16'h5A02);

        // Flush with stall: PC held, register still flushed
        stall = 1'b1;
        flush = 1'b1;
        edge_step();
        stall = 1'b0;
        flush = 1'b0;
        check("flush_stall_pc", address_pc, 16'h0003);
        check("flush_stall_id", instruction_decode, 16'h0000);

        // Async reset between edges at PC=0123
        NI   = 1'b1;
        srcB = 16'h0123;
        edge_step();
        NI   = 1'b0;
        srcB = 16'h0000;
        check("pre_async_pc", address_pc, 16'h0123);
        check("pre_async_id", instruction_decode, 16'h5A03);
        #2;
        reset = 1'b0;
        #1;
        check("async_pc", address_pc, 16'h0000);
        check("async_pc1", pc_plus_one, 16'h0001);
        check("async_id", instruction_decode, 16'h0000);
        edge_step();
        check("async_hold_pc", address_pc, 16'h0000);
        reset = 1'b1;
        edge_step();
        check("release_pc", address_pc, 16'h0001);
        check("release_id", instruction_decode, 16'h5A00);

        // Standalone ALU
        alu_case("add_ovf", 3'b001, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b0);
        alu_case("sub_zero", 3'b010, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b1);
        alu_case("sub_neg", 3'b010, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0);
        alu_case("shl", 3'b101, 16'h0001, 16'h0004, 16'h0010, 1'b0, 1'b0);
        alu_case("xor_zero", 3'b100, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1);
        alu_case("and", 3'b000, 16'hF0F0, 16'hFF00, 16'hF000, 1'b1, 1'b0);
        alu_case("or", 3'b011, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 1'b0);
        alu_case("shr_low_bits", 3'b110, 16'h8000, 16'h0013, 16'h1000, 1'b0, 1'b0);
        alu_case("pass_b", 3'b111, 16'hAAAA, 16'h1234, 16'h1234, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
